// File: rtl/pc_stack_sequencer.sv
// pc_stack_sequencer
// Drives the two-word PC push/pop protocol toward the EX/MEM stage for CALL, RET, RTI
// and external interrupts, and stalls the front end while a sequence is in flight.
// Optional build macro: PC_STACK_GUARD_EN adds a stack-depth guard with a sticky error.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | accepting commands / serving a pending interrupt
// S_PUSH_HI | writing first PC word (CALL or INT)
// S_PUSH_LO | writing second PC word; CALL branches here
// S_POP_LO  | reading first PC word (RET or RTI)
// S_POP_HI  | reading second PC word
// S_VEC     | loading the interrupt vector, acknowledging the interrupt
module pc_stack_sequencer #(
    parameter int DEPTH_W = 11
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_call,
    input  logic i_ret,
    input  logic i_rti,
    input  logic i_int,
    output logic o_stack_operation,
    output logic o_stack_function,
    output logic o_mem_read,
    output logic o_mem_write,
    output logic o_push_pc,
    output logic o_pop_pc,
    output logic o_hazard_state,
    output logic o_branch_flags,
    output logic o_branch_en,
    output logic o_vector_load,
    output logic o_int_ack,
    output logic o_int_pending,
    output logic o_stall,
    output logic o_stack_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH_HI, S_PUSH_LO, S_POP_LO, S_POP_HI, S_VEC
    } state_t;

    typedef enum logic [1:0] {
        K_CALL, K_INT, K_RET, K_RTI
    } kind_t;

    // The guard compares against depth-2 and depth+2, so fewer than two bits is meaningless.
    if (DEPTH_W < 2) begin : g_depth_w_check
        $error("pc_stack_sequencer: DEPTH_W must be at least 2");
    end

    state_t state, state_nxt;
    kind_t  kind, kind_nxt;
    logic   pending;
    logic   pend_clr;
    logic   ok_pop;
    logic   ok_push;

`ifdef PC_STACK_GUARD_EN
    localparam logic [DEPTH_W-1:0] POP_MIN  = DEPTH_W'(2);
    localparam logic [DEPTH_W-1:0] PUSH_MAX = {DEPTH_W{1'b1}} - DEPTH_W'(2);

    logic [DEPTH_W-1:0] depth;
    logic               stack_err;
    logic               err_set;

    assign ok_pop  = (depth >= POP_MIN);
    assign ok_push = (depth <= PUSH_MAX);

    // A refused command in IDLE flags the error; the priority winner decides which check applies.
    assign err_set = (state == S_IDLE) &&
                     ((i_rti || i_ret) ? !ok_pop : ((i_call || pending) && !ok_push));

    // Word-depth tracking follows the words actually moved, one per push/pop cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            depth <= '0;
        end else if (state == S_PUSH_HI || state == S_PUSH_LO) begin
            depth <= depth + DEPTH_W'(1);
        end else if (state == S_POP_LO || state == S_POP_HI) begin
            depth <= depth - DEPTH_W'(1);
        end
    end

    // Sticky error, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stack_err <= 1'b0;
        end else if (err_set) begin
            stack_err <= 1'b1;
        end
    end

    assign o_stack_err = stack_err;
`else
    assign ok_pop      = 1'b1;
    assign ok_push     = 1'b1;
    assign o_stack_err = 1'b0;
`endif

    // State and sequence-kind registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
            kind  <= K_CALL;
        end else begin
            state <= state_nxt;
            kind  <= kind_nxt;
        end
    end

    // Interrupt latch; serving it wins over a new request in the same cycle (that request is lost).
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pending <= 1'b0;
        end else if (pend_clr) begin
            pending <= 1'b0;
        end else if (i_int) begin
            pending <= 1'b1;
        end
    end

    assign o_int_pending = pending;

    // Next-state selection and Moore output decode from state/kind.
    always_comb begin
        state_nxt         = state;
        kind_nxt          = kind;
        pend_clr          = 1'b0;
        o_stack_operation = 1'b0;
        o_stack_function  = 1'b0;
        o_mem_read        = 1'b0;
        o_mem_write       = 1'b0;
        o_push_pc         = 1'b0;
        o_pop_pc          = 1'b0;
        o_hazard_state    = 1'b0;
        o_branch_flags    = 1'b0;
        o_branch_en       = 1'b0;
        o_vector_load     = 1'b0;
        o_int_ack         = 1'b0;
        o_stall           = 1'b1;

        case (state)
            S_IDLE: begin
                o_stall = 1'b0;
                if (i_rti) begin
                    if (ok_pop) begin
                        state_nxt = S_POP_LO;
                        kind_nxt  = K_RTI;
                    end
                end else if (i_ret) begin
                    if (ok_pop) begin
                        state_nxt = S_POP_LO;
                        kind_nxt  = K_RET;
                    end
                end else if (i_call) begin
                    if (ok_push) begin
                        state_nxt = S_PUSH_HI;
                        kind_nxt  = K_CALL;
                    end
                end else if (pending) begin
                    // A refused interrupt stays latched.
                    if (ok_push) begin
                        state_nxt = S_PUSH_HI;
                        kind_nxt  = K_INT;
                        pend_clr  = 1'b1;
                    end
                end
            end
            S_PUSH_HI: begin
                o_stack_operation = 1'b1;
                o_stack_function  = 1'b1;
                o_mem_write       = 1'b1;
                o_push_pc         = 1'b1;
                o_branch_flags    = (kind == K_INT);
                state_nxt         = S_PUSH_LO;
            end
            S_PUSH_LO: begin
                o_stack_operation = 1'b1;
                o_stack_function  = 1'b1;
                o_mem_write       = 1'b1;
                o_push_pc         = 1'b1;
                o_hazard_state    = 1'b1;
                o_branch_flags    = (kind == K_INT);
                o_branch_en       = (kind == K_CALL);
                state_nxt         = (kind == K_INT) ? S_VEC : S_IDLE;
            end
            S_POP_LO: begin
                o_stack_operation = 1'b1;
                o_mem_read        = 1'b1;
                o_pop_pc          = 1'b1;
                o_branch_flags    = (kind == K_RTI);
                state_nxt         = S_POP_HI;
            end
            S_POP_HI: begin
                o_stack_operation = 1'b1;
                o_mem_read        = 1'b1;
                o_pop_pc          = 1'b1;
                o_hazard_state    = 1'b1;
                o_branch_flags    = (kind == K_RTI);
                state_nxt         = S_IDLE;
            end
            S_VEC: begin
                o_vector_load = 1'b1;
                o_int_ack     = 1'b1;
                state_nxt     = S_IDLE;
            end
            default: begin
                o_stall   = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Bench for pc_stack_sequencer: directed scenarios plus random traffic against a
// sequence-scheduling reference model (queue of expected output words per cycle).
module tb_pc_stack_sequencer;

    localparam int DEPTH_W = 11;
`ifdef PC_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_reset = 1'b0;
    logic i_call = 1'b0, i_ret = 1'b0, i_rti = 1'b0, i_int = 1'b0;
    logic o_stack_operation, o_stack_function, o_mem_read, o_mem_write;
    logic o_push_pc, o_pop_pc, o_hazard_state, o_branch_flags, o_branch_en;
    logic o_vector_load, o_int_ack, o_int_pending, o_stall, o_stack_err;

    int n_checks = 0;
    int n_fail   = 0;

    pc_stack_sequencer #(.DEPTH_W(DEPTH_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_call(i_call), .i_ret(i_ret), .i_rti(i_rti), .i_int(i_int),
        .o_stack_operation(o_stack_operation), .o_stack_function(o_stack_function),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_push_pc(o_push_pc), .o_pop_pc(o_pop_pc),
        .o_hazard_state(o_hazard_state), .o_branch_flags(o_branch_flags),
        .o_branch_en(o_branch_en), .o_vector_load(o_vector_load),
        .o_int_ack(o_int_ack), .o_int_pending(o_int_pending),
        .o_stall(o_stall), .o_stack_err(o_stack_err)
    );

    always #5 i_clk = ~i_clk;

    // Output word: {stack_op, stack_fn, mem_rd, mem_wr, push_pc, pop_pc, hazard, flags, branch_en, vec_load, int_ack, stall}
    wire [11:0] obs = {o_stack_operation, o_stack_function, o_mem_read, o_mem_write,
                       o_push_pc, o_pop_pc, o_hazard_state, o_branch_flags,
                       o_branch_en, o_vector_load, o_int_ack, o_stall};

    function automatic logic [11:0] w_push(input bit second, input bit flags, input bit br);
        return {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, second, flags, br, 1'b0, 1'b0, 1'b1};
    endfunction

    function automatic logic [11:0] w_pop(input bit second, input bit flags);
        return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, second, flags, 1'b0, 1'b0, 1'b0, 1'b1};
    endfunction

    function automatic logic [11:0] w_vec();
        return 12'b0000_0000_0111;
    endfunction

    // Reference model: queued output words for the sequence in flight, pending latch, depth, error.
    logic [11:0] exp_q[$];
    logic [11:0] exp_now;
    logic        m_pend;
    logic        m_err;
    int          m_depth;

    task automatic model_reset();
        exp_q.delete();
        exp_now = '0;
        m_pend  = 1'b0;
        m_err   = 1'b0;
        m_depth = 0;
    endtask

    task automatic model_edge();
        bit served = 1'b0;
        bit pop_ok  = !GUARD || (m_depth >= 2);
        bit push_ok = !GUARD || (m_depth <= (2 ** DEPTH_W) - 3);
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end else if (i_rti || i_ret) begin
            if (pop_ok) begin
                exp_q.push_back(w_pop(0, i_rti));
                exp_q.push_back(w_pop(1, i_rti));
                m_depth -= 2;
            end else m_err = 1'b1;
        end else if (i_call) begin
            if (push_ok) begin
                exp_q.push_back(w_push(0, 0, 0));
                exp_q.push_back(w_push(1, 0, 1));
                m_depth += 2;
            end else m_err = 1'b1;
        end else if (m_pend) begin
            if (push_ok) begin
                exp_q.push_back(w_push(0, 1, 0));
                exp_q.push_back(w_push(1, 1, 0));
                exp_q.push_back(w_vec());
                m_depth += 2;
                served = 1'b1;
            end else m_err = 1'b1;
        end
        m_pend  = served ? 1'b0 : (m_pend | i_int);
        exp_now = (exp_q.size() != 0) ? exp_q[0] : 12'h000;
    endtask

    // One clock: present inputs, let the edge happen, advance the model, settle, drop pulses.
    task automatic tick(input bit c, input bit r, input bit t, input bit n);
        i_call = c; i_ret = r; i_rti = t; i_int = n;
        @(posedge i_clk);
        model_edge();
        #1;
        i_call = 1'b0; i_ret = 1'b0; i_rti = 1'b0; i_int = 1'b0;
    endtask

    task automatic apply_reset();
        i_reset = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        n_checks++;
        if ({obs, o_int_pending, o_stack_err} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want all zero", {obs, o_int_pending, o_stack_err});
        end
        i_reset = 1'b1;
        tick(0, 0, 0, 0);
        n_checks++;
        if (obs !== 12'h000 || obs !== exp_now) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want %b", obs, exp_now);
        end
    endtask

    task automatic test_call();
        int stalls;
        tick(1, 0, 0, 0);
        stalls = int'(o_stall);
        n_checks++;
        if (obs !== w_push(0, 0, 0) || obs !== exp_now) begin
            n_fail++;
            $display("FAIL call_push_hi: got %b want %b", obs, w_push(0, 0, 0));
        end
        tick(0, 0, 0, 0);
        stalls += int'(o_stall);
        n_checks++;
        if (obs !== w_push(1, 0, 1) || obs !== exp_now) begin
            n_fail++;
            $display("FAIL call_push_lo: got %b want %b", obs, w_push(1, 0, 1));
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0);
            stalls += int'(o_stall);
            n_checks++;
            if (obs !== exp_now) begin
                n_fail++;
                $display("FAIL call_tail[%0d]: got %b want %b", i, obs, exp_now);
            end
        end
        n_checks++;
        if (stalls != 2) begin
            n_fail++;
            $display("FAIL call_stall_cycles: got %0d want 2", stalls);
        end
    endtask

    task automatic test_rti();
        tick(0, 0, 1, 0);
        n_checks++;
        if (obs !== w_pop(0, 1) || obs !== exp_now) begin
            n_fail++;
            $display("FAIL rti_pop_lo: got %b want %b", obs, w_pop(0, 1));
        end
        tick(0, 0, 0, 0);
        n_checks++;
        if (obs !== w_pop(1, 1) || obs !== exp_now) begin
            n_fail++;
            $display("FAIL rti_pop_hi: got %b want %b", obs, w_pop(1, 1));
        end
        tick(0, 0, 0, 0);
        n_checks++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL rti_done: got %b want 000000000000", obs);
        end
    endtask

    task automatic test_int_during_call();
        logic [11:0] want[5];
        logic        want_p[5];
        want   = '{w_push(1, 0, 1), 12'h000, w_push(0, 1, 0), w_push(1, 1, 0), w_vec()};
        want_p = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tick(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, i == 0);
            n_checks++;
            if (obs !== want[i] || o_int_pending !== want_p[i] || obs !== exp_now) begin
                n_fail++;
                $display("FAIL int_after_call[%0d]: got %b pend %b want %b pend %b",
                         i, obs, o_int_pending, want[i], want_p[i]);
            end
        end
        tick(0, 0, 0, 0);
        n_checks++;
        if (obs !== 12'h000 || o_int_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL int_done: got %b pend %b want idle pend 0", obs, o_int_pending);
        end
    endtask

    task automatic test_priority();
        logic [11:0] want[7];
        bit          saw_branch = 1'b0;
        want = '{w_pop(0, 1), w_pop(1, 1), 12'h000, w_push(0, 1, 0),
                 w_push(1, 1, 0), w_vec(), 12'h000};
        tick(0, 0, 0, 1);
        n_checks++;
        if (o_int_pending !== 1'b1 || obs !== 12'h000) begin
            n_fail++;
            $display("FAIL prio_pending_set: pend %b obs %b want pend 1 idle", o_int_pending, obs);
        end
        tick(1, 0, 1, 0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick(0, 0, 0, 0);
            saw_branch |= o_branch_en;
            n_checks++;
            if (obs !== want[i] || obs !== exp_now) begin
                n_fail++;
                $display("FAIL prio_seq[%0d]: got %b want %b", i, obs, want[i]);
            end
        end
        n_checks++;
        if (saw_branch) begin
            n_fail++;
            $display("FAIL prio_call_dropped: branch_en seen 1 want never");
        end
    endtask

    task automatic test_reset_mid_pop();
        repeat (3) tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0);
        tick(0, 1, 0, 1);
        n_checks++;
        if (obs !== w_pop(0, 0) || o_int_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_pop: got %b pend %b want %b pend 1", obs, o_int_pending, w_pop(0, 0));
        end
        #2;
        i_reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({obs, o_int_pending, o_stack_err} !== 14'h0) begin
            n_fail++;
            $display("FAIL rst_async_clear: got %b want all zero", {obs, o_int_pending, o_stack_err});
        end
        @(posedge i_clk);
        #1;
        n_checks++;
        if ({obs, o_int_pending} !== 13'h0) begin
            n_fail++;
            $display("FAIL rst_hold: got %b want all zero", {obs, o_int_pending});
        end
        i_reset = 1'b1;
        tick(0, 0, 0, 0);
        n_checks++;
        if (obs !== 12'h000 || o_int_pending !== 1'b0 || obs !== exp_now) begin
            n_fail++;
            $display("FAIL rst_idle_after: got %b pend %b want idle pend 0", obs, o_int_pending);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            n_checks++;
            if ({obs, o_int_pending, o_stack_err} !== {exp_now, m_pend, m_err}) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b/%b/%b want %b/%b/%b", i,
                         obs, o_int_pending, o_stack_err, exp_now, m_pend, m_err);
            end
        end
        repeat (4) tick(0, 0, 0, 0);
    endtask

`ifdef PC_STACK_GUARD_EN
    task automatic test_guard();
        apply_reset();
        tick(0, 1, 0, 0);
        n_checks++;
        if (o_stack_err !== 1'b1 || obs !== 12'h000) begin
            n_fail++;
            $display("FAIL guard_ret_empty: err %b obs %b want err 1 idle", o_stack_err, obs);
        end
        apply_reset();
        tick(1, 0, 0, 0);
        repeat (2) tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        n_checks++;
        if (obs !== w_pop(0, 0) || o_stack_err !== 1'b0) begin
            n_fail++;
            $display("FAIL guard_ret_ok: got %b err %b want %b err 0", obs, o_stack_err, w_pop(0, 0));
        end
        repeat (2) tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        n_checks++;
        if (o_stack_err !== 1'b1 || obs !== 12'h000) begin
            n_fail++;
            $display("FAIL guard_rti_after_drain: err %b obs %b want err 1 idle", o_stack_err, obs);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_call();
        test_rti();
        test_int_during_call();
        test_priority();
        test_reset_mid_pop();
        test_random();
`ifdef PC_STACK_GUARD_EN
        test_guard();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
